mat_weight_loader: RTL and testbench
====================================

# mat_weight_loader

Sequencer that fills the systolic matrix unit's weight registers from matrix data memory. On a start pulse it walks `row_count` rows of data memory from a base address with a programmable stride, presents one row per cycle to the matrix unit's weight port with the matching row index, and reports completion with a one-cycle `done` pulse. It sits between the matrix controller, which issues the command, and the matrix unit / data memory read port. During a load it owns the unit's `set_weight` path.

## Interface
- `WIDTH`, 16, matrix dimension: lanes per row and number of weight rows.
- `DATA_MEM_ADDR_SIZE`, 32, data memory address width.
- `WIDTH_ADDR_SIZE`, `$clog2(WIDTH)`, row index width (derived).

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  command strobe; sampled only while `busy`=0.
- `abort`  in  1  terminate the current load.
- `base_addr`  in  DATA_MEM_ADDR_SIZE  address of weight row 0.
- `stride`  in  DATA_MEM_ADDR_SIZE  address increment between rows.
- `row_count`  in  WIDTH_ADDR_SIZE+1  rows to load; legal range 1..WIDTH.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  qualifies `done`: illegal `row_count` or abort.
- `data_mem_read_addr`  out  DATA_MEM_ADDR_SIZE  row address to data memory.
- `data_mem_data_out`  in  shortreal[WIDTH]  combinational read data for `data_mem_read_addr`.
- `unit_set_weight`  out  1  write enable to the matrix unit weight rows.
- `unit_set_weight_row`  out  WIDTH_ADDR_SIZE  target weight row.
- `unit_data_in`  out  shortreal[WIDTH]  row data to the matrix unit.

## Operation
- States: IDLE, FETCH, DRAIN, FIN.
- IDLE + `start`=1: latch `base_addr`, `stride`, `row_count`. Set N = `row_count`.
  - N=0 or N>WIDTH: go to FIN with `error` set. No unit writes.
  - Otherwise: go to FETCH with issue counter k=0 and address = base.
- FETCH:
  - Drive `data_mem_read_addr` = base + k*stride, modulo 2^DATA_MEM_ADDR_SIZE (wrap, no error).
  - Register the returned row and its index k into a one-stage pipeline register.
  - Increment k and add `stride` to the address register; no multiplier.
  - After issuing row N-1, go to DRAIN.
- Pipeline stage valid: `unit_set_weight`=1, `unit_set_weight_row` = registered k, `unit_data_in` = registered row.
- DRAIN: emit the last pipelined row, then go to FIN.
- FIN: `done`=1 for one cycle, `busy`=0, then IDLE.
- `abort`=1 while `busy`:
  - Next cycle: `unit_set_weight`=0, pipeline is discarded, state is FIN with `error`=1.
  - Rows already written stay written.
- `abort` while idle: no effect. `start` and `abort` in the same cycle while idle: abort wins, start is dropped.
- `start` while `busy`: ignored, with no queueing.
- `error` is valid only when `done`=1; otherwise it is 0.

## Timing
- Let E0 be the edge that samples `start` (legal N). Cycles after E0 are c1, c2, …:
  - c1: `busy`=1, address of row 0.
  - c(k+2): write of row k, overlapped with the address of row k+1.
  - c(N+1): last write.
  - c(N+2): `done`=1, `busy`=0.
- Throughput: one row per cycle.
- Illegal N: `done`=`error`=1 in c1.
- `busy` is 1 from c1 through the last write, and 0 in the FIN cycle.
- Reset (`reset`=0 at an edge) values, effective immediately from any state, including mid-load:
  - state IDLE
  - `busy`=`done`=`error`=`unit_set_weight`=0
  - `unit_set_weight_row`=0
  - `data_mem_read_addr`=0
  - `unit_data_in` all lanes 0.0
  - No further unit writes after the reset edge.
- When no write is in progress, `unit_data_in` is held at 0.0 and `unit_set_weight_row` at 0.

## Configuration
- `MAT_WEIGHT_LOAD_ZERO_FILL_EN` defined:
  - After row N-1, rows N..WIDTH-1 are written with all-0.0 data, one per cycle, and no memory reads are issued for them.
  - `done` moves to c(WIDTH+2).
  - Abort also stops the zero fill.
- `MAT_WEIGHT_LOAD_ZERO_FILL_EN` undefined: only rows 0..N-1 are written; rows N..WIDTH-1 keep their previous contents.

## Test plan
- WIDTH=16, base=100, stride=1, N=16, memory row r = r+0.5 in all lanes → rows 0..15 written in c2..c17 with value r+0.5; `done` in c18 with `error`=0.
- base=2^32-2, stride=3, N=3 → read addresses 2^32-2, 1, 4 (wrap); three writes; `done` in c5.
- N=4, with and without `MAT_WEIGHT_LOAD_ZERO_FILL_EN` → with it, rows 4..15 are 0.0 and `done` arrives in c18; without it, rows 4..15 are unchanged and `done` arrives in c6.
- `abort` asserted in c4 of an N=16 load → rows 0..2 written (c2..c4); no write in c5; `done`=`error`=1 in c5.
- N=0 → `done`=`error`=1 in c1, no `unit_set_weight`. N=17 gives the same response. A `start` in c3 of a legal load is ignored.
- `reset`=0 in c6 of an N=16 load → next cycle all outputs at reset values and no further writes; a new `start` after release loads normally.

Source files
------------

// File: rtl/mat_weight_loader.sv
// mat_weight_loader: streams weight rows from data memory into the matrix unit.
// Optional build macro MAT_WEIGHT_LOAD_ZERO_FILL_EN zero-fills unused rows.

module mat_weight_loader #(
  parameter int WIDTH              = 16,
  parameter int DATA_MEM_ADDR_SIZE = 32,
  parameter int WIDTH_ADDR_SIZE    = $clog2(WIDTH)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [DATA_MEM_ADDR_SIZE-1:0]    base_addr,
  input  logic [DATA_MEM_ADDR_SIZE-1:0]    stride,
  input  logic [WIDTH_ADDR_SIZE:0]         row_count,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [DATA_MEM_ADDR_SIZE-1:0]    data_mem_read_addr,
  input  logic [WIDTH-1:0][31:0]           data_mem_data_out,
  output logic                             unit_set_weight,
  output logic [WIDTH_ADDR_SIZE-1:0]       unit_set_weight_row,
  output logic [WIDTH-1:0][31:0]           unit_data_in
);

  // Lanes carry IEEE-754 single-precision bit patterns; 0.0 is all zeros.

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam logic [WIDTH_ADDR_SIZE:0] LP_WMAX =
    (WIDTH_ADDR_SIZE+1)'(WIDTH);

  state_t                          r_state;
  state_t                          w_next;
  logic [DATA_MEM_ADDR_SIZE-1:0]   r_addr;
  logic [DATA_MEM_ADDR_SIZE-1:0]   r_stride;
  logic [WIDTH_ADDR_SIZE-1:0]      r_k;
  logic [WIDTH_ADDR_SIZE-1:0]      r_nlast;
  logic                            r_err;
  logic                            r_pv;
  logic [WIDTH_ADDR_SIZE-1:0]      r_prow;
  logic [WIDTH-1:0][31:0]          r_pdata;

  logic                            w_go;
  logic                            w_legal;
  logic                            w_fill;
  logic [WIDTH_ADDR_SIZE-1:0]      w_klast;

  assign w_go    = start && !abort;
  assign w_legal = (row_count != '0) && (row_count <= LP_WMAX);

`ifdef MAT_WEIGHT_LOAD_ZERO_FILL_EN
  localparam logic [WIDTH_ADDR_SIZE-1:0] LP_KMAX =
    WIDTH_ADDR_SIZE'(WIDTH - 1);
  // Past the last real row the issue slot carries a zero row, no read.
  assign w_fill  = (r_k > r_nlast);
  assign w_klast = LP_KMAX;
`else
  assign w_fill  = 1'b0;
  assign w_klast = r_nlast;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and status outputs
  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    error  = 1'b0;
    data_mem_read_addr = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_next = w_legal ? S_FETCH : S_FIN;
        end
      end
      S_FETCH: begin
        busy = 1'b1;
        if (!w_fill) begin
          data_mem_read_addr = r_addr;
        end
        if (abort) begin
          w_next = S_FIN;
        end else if (r_k == w_klast) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy   = 1'b1;
        w_next = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        error  = r_err;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Command latch, issue counter and address accumulator
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_k      <= '0;
      r_nlast  <= '0;
      r_err    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_addr   <= base_addr;
            r_stride <= stride;
            r_k      <= '0;
            r_nlast  <= row_count[WIDTH_ADDR_SIZE-1:0]
                        - WIDTH_ADDR_SIZE'(1);
            r_err    <= !w_legal;
          end
        end
        S_FETCH: begin
          if (abort) begin
            r_err <= 1'b1;
          end else begin
            r_k    <= r_k + WIDTH_ADDR_SIZE'(1);
            r_addr <= r_addr + r_stride;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_err <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Write pipeline stage; cleared whenever no row is captured
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_pv    <= 1'b0;
      r_prow  <= '0;
      r_pdata <= '0;
    end else if (r_state == S_FETCH && !abort) begin
      r_pv    <= 1'b1;
      r_prow  <= r_k;
      r_pdata <= w_fill ? '0 : data_mem_data_out;
    end else begin
      r_pv    <= 1'b0;
      r_prow  <= '0;
      r_pdata <= '0;
    end
  end

  assign unit_set_weight     = r_pv;
  assign unit_set_weight_row = r_prow;
  assign unit_data_in        = r_pdata;

endmodule

// File: tb/tb_mat_weight_loader.sv
// tb_mat_weight_loader: table-driven loads with a write scoreboard.
// Zero-fill expectations follow MAT_WEIGHT_LOAD_ZERO_FILL_EN.

module tb_mat_weight_loader;

  localparam int W  = 16;
  localparam int AW = 32;
  localparam int IW = 4;
`ifdef MAT_WEIGHT_LOAD_ZERO_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  typedef logic [W-1:0][31:0] row_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] stride = '0;
  logic [IW:0]   row_count = '0;
  logic          busy, done, error;
  logic [AW-1:0] data_mem_read_addr;
  row_t          data_mem_data_out;
  logic          unit_set_weight;
  logic [IW-1:0] unit_set_weight_row;
  row_t          unit_data_in;

  always #5 clock = ~clock;

  mat_weight_loader dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .abort               (abort),
    .base_addr           (base_addr),
    .stride              (stride),
    .row_count           (row_count),
    .busy                (busy),
    .done                (done),
    .error               (error),
    .data_mem_read_addr  (data_mem_read_addr),
    .data_mem_data_out   (data_mem_data_out),
    .unit_set_weight     (unit_set_weight),
    .unit_set_weight_row (unit_set_weight_row),
    .unit_data_in        (unit_data_in)
  );

  // IEEE-754 single encoding of r + 0.5 for small r >= 0
  function automatic logic [31:0] fhalf(int r);
    int m;
    int p;
    logic [31:0] e;
    logic [31:0] mt;
    m = 2 * r + 1;
    p = 0;
    for (int i = 0; i < 31; i++)
      if (((m >> i) & 1) != 0) p = i;
    e  = 32'(126 + p);
    mt = 32'(m << (23 - p)) & 32'h007F_FFFF;
    return {1'b0, e[7:0], mt[22:0]};
  endfunction

  function automatic row_t mem_row(logic [31:0] a);
    row_t d;
    for (int l = 0; l < W; l++) begin
      if (a >= 32'd100 && a < 32'd132)
        d[l] = fhalf(int'(a - 32'd100));
      else
        d[l] = {a[23:0], 8'(l)};
    end
    return d;
  endfunction

  always_comb data_mem_data_out = mem_row(data_mem_read_addr);

  typedef struct {
    logic [IW-1:0] row;
    row_t          data;
  } wr_t;

  wr_t sbq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every observed unit write must match the next expected one
  always @(negedge clock) begin
    if (unit_set_weight === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got row %0d want none",
                 unit_set_weight_row);
      end else begin
        wr_t e;
        e = sbq.pop_front();
        if (e.row !== unit_set_weight_row || e.data !== unit_data_in) begin
          errors++;
          $display("FAIL write_row%0d: got row %0d data %h want data %h",
                   e.row, unit_set_weight_row, unit_data_in, e.data);
        end
      end
    end
  end

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    int          n;
    int          abort_c;
    int          restart_c;
  } vec_t;

  vec_t vt[8];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(int vi, vec_t v);
    bit legal;
    int total, dc, nw;
    bit err;
    logic [31:0] ea;
    legal = (v.n >= 1 && v.n <= W);
    total = FILL ? W : v.n;
    if (!legal) begin
      dc = 1; err = 1'b1; nw = 0;
    end else if (v.abort_c != 0 && v.abort_c < total + 2) begin
      dc = v.abort_c + 1; err = 1'b1; nw = v.abort_c - 1;
    end else begin
      dc = total + 2; err = 1'b0; nw = total;
    end
    for (int k = 0; k < nw; k++) begin
      wr_t e;
      e.row  = IW'(k);
      e.data = (k < v.n) ? mem_row(v.base + v.stride * 32'(k)) : '0;
      sbq.push_back(e);
    end
    base_addr = v.base;
    stride    = v.stride;
    row_count = (IW+1)'(v.n);
    start     = 1'b1;
    tick();
    for (int c = 1; c <= dc + 1; c++) begin
      abort = (c == v.abort_c);
      if (c == v.restart_c) begin
        start = 1'b1; base_addr = '0; row_count = (IW+1)'(1);
      end else begin
        start = 1'b0;
      end
      ea = (legal && c <= v.n && c < dc) ? v.base + v.stride * 32'(c - 1) : '0;
      chk($sformatf("v%0d_c%0d_busy", vi, c), 64'(busy),
          64'(legal && c < dc));
      chk($sformatf("v%0d_c%0d_done", vi, c), 64'(done), 64'(c == dc));
      chk($sformatf("v%0d_c%0d_error", vi, c), 64'(error),
          64'(c == dc && err));
      chk($sformatf("v%0d_c%0d_we", vi, c), 64'(unit_set_weight),
          64'(c >= 2 && c < 2 + nw));
      chk($sformatf("v%0d_c%0d_addr", vi, c), 64'(data_mem_read_addr),
          64'(ea));
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    chk($sformatf("v%0d_pending_writes", vi), 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    vt[0] = '{32'd100, 32'd1, 16, 0, 0};
    vt[1] = '{32'hFFFF_FFFE, 32'd3, 3, 0, 0};
    vt[2] = '{32'd200, 32'd16, 4, 0, 0};
    vt[3] = '{32'd100, 32'd1, 16, 4, 0};
    vt[4] = '{32'd100, 32'd1, 0, 0, 0};
    vt[5] = '{32'd100, 32'd1, 17, 0, 0};
    vt[6] = '{32'd100, 32'd1, 5, 0, 3};
    vt[7] = '{32'd50, 32'd2, 1, 0, 0};

    reset = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_we", 64'(unit_set_weight), 64'd0);
    chk("rst_row", 64'(unit_set_weight_row), 64'd0);
    chk("rst_addr", 64'(data_mem_read_addr), 64'd0);
    chk("rst_data_zero", 64'(unit_data_in == '0), 64'd1);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vt[i]);
      tick();
    end

    // start and abort together while idle: abort wins
    start = 1'b1;
    abort = 1'b1;
    row_count = 5'd4;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("sa_c%0d_busy", c), 64'(busy), 64'd0);
      chk($sformatf("sa_c%0d_done", c), 64'(done), 64'd0);
      tick();
    end

    // reset in c6 of a 16-row load: rows 0..4 written, then nothing
    for (int k = 0; k < 5; k++) begin
      wr_t e;
      e.row  = IW'(k);
      e.data = mem_row(32'd100 + 32'(k));
      sbq.push_back(e);
    end
    base_addr = 32'd100;
    stride    = 32'd1;
    row_count = 5'd16;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    chk("mr_c6_we", 64'(unit_set_weight), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    chk("mr_error", 64'(error), 64'd0);
    chk("mr_we", 64'(unit_set_weight), 64'd0);
    chk("mr_row", 64'(unit_set_weight_row), 64'd0);
    chk("mr_addr", 64'(data_mem_read_addr), 64'd0);
    chk("mr_data_zero", 64'(unit_data_in == '0), 64'd1);
    for (int c = 0; c < 20; c++) tick();
    chk("mr_pending_writes", 64'(sbq.size()), 64'd0);
    run_vec(8, vt[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
